// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - Shared widths, ALU op codes, stage states and helpers for the ALU execute stage
package alu_pkg;

  localparam int NBITS   = 32;
  localparam int ALUOP   = 4;
  localparam int NBSHAMT = 5;

  localparam logic [ALUOP-1:0] OP_AND  = 4'b0000;
  localparam logic [ALUOP-1:0] OP_OR   = 4'b0001;
  localparam logic [ALUOP-1:0] OP_ADD  = 4'b0010;
  localparam logic [ALUOP-1:0] OP_SLL  = 4'b0011;
  localparam logic [ALUOP-1:0] OP_SRL  = 4'b0100;
  localparam logic [ALUOP-1:0] OP_SLLV = 4'b0101;
  localparam logic [ALUOP-1:0] OP_SUB  = 4'b0110;
  localparam logic [ALUOP-1:0] OP_SLT  = 4'b0111;
  localparam logic [ALUOP-1:0] OP_SRLV = 4'b1000;
  localparam logic [ALUOP-1:0] OP_NOR  = 4'b1100;
  localparam logic [ALUOP-1:0] OP_XOR  = 4'b1101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [NBITS-1:0] ILLEGAL_RESULT = '0;

  function automatic logic [NBITS-1:0] shift_one(input logic [NBITS-1:0] v, input logic left);
    return left ? {v[NBITS-2:0], 1'b0} : {1'b0, v[NBITS-1:1]};
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - Operation request / registered result handshake bundle
interface alu_exec_stage_if;
  import alu_pkg::*;

  logic               i_Valid;
  logic               o_Ready;
  logic [ALUOP-1:0]   i_ALUOp;
  logic [NBITS-1:0]   i_DatoA;
  logic [NBITS-1:0]   i_DatoB;
  logic [NBSHAMT-1:0] i_Shamt;
  logic               o_Valid;
  logic               i_Ready;
  logic [NBITS-1:0]   o_Result;
  logic               o_Zero;
  logic               o_Error;

  modport master (
    output i_Valid, i_ALUOp, i_DatoA, i_DatoB, i_Shamt, i_Ready,
    input  o_Ready, o_Valid, o_Result, o_Zero, o_Error
  );

  modport slave (
    input  i_Valid, i_ALUOp, i_DatoA, i_DatoB, i_Shamt, i_Ready,
    output o_Ready, o_Valid, o_Result, o_Zero, o_Error
  );

endinterface

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - Shifter: iterative 1 bit/cycle by default, barrel when ALU_FAST_SHIFT_EN is defined
module alu_shift_unit
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               left,
  input  logic [NBITS-1:0]   data,
  input  logic [NBSHAMT-1:0] amount,
  output logic [NBITS-1:0]   result,
  output logic               last
);

`ifdef ALU_FAST_SHIFT_EN

  assign result = left ? (data << amount) : (data >> amount);
  assign last   = 1'b0;

`else

  logic [NBITS-1:0]   work;
  logic [NBSHAMT-1:0] count;
  logic               dir_left;

  // The first bit is shifted while loading, so an n-bit shift completes on the n-th edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      count    <= '0;
      dir_left <= 1'b0;
    end else if (load) begin
      work     <= shift_one(data, left);
      count    <= amount - NBSHAMT'(1);
      dir_left <= left;
    end else if (count != '0) begin
      work  <= shift_one(work, dir_left);
      count <= count - NBSHAMT'(1);
    end
  end

  assign result = shift_one(work, dir_left);
  assign last   = (count == NBSHAMT'(1));

`endif

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - Execute-stage ALU with single-entry result register; ALU_FAST_SHIFT_EN selects barrel shifts
module alu_exec_stage
  import alu_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_reset,
  alu_exec_stage_if.slave bus
);

  logic [1:0]         state;
  logic [NBITS-1:0]   result_q;
  logic               zero_q;
  logic               error_q;

  logic               accept;
  logic               is_shift;
  logic               shift_left;
  logic               legal;
  logic               go_shift;
  logic               sh_last;
  logic [NBSHAMT-1:0] amount;
  logic [NBITS-1:0]   logic_res;
  logic [NBITS-1:0]   alu_res;
  logic [NBITS-1:0]   sh_res;

`ifdef ALU_FAST_SHIFT_EN
  assign bus.o_Ready = !bus.o_Valid || bus.i_Ready;
  assign go_shift    = 1'b0;
`else
  assign bus.o_Ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.i_Ready);
  assign go_shift    = is_shift && (amount > NBSHAMT'(1));
`endif

  assign bus.o_Valid  = (state == ST_DONE);
  assign bus.o_Result = result_q;
  assign bus.o_Zero   = zero_q;
  assign bus.o_Error  = error_q;
  assign accept       = bus.i_Valid && bus.o_Ready;

  always_comb begin
    is_shift   = 1'b0;
    shift_left = 1'b0;
    legal      = 1'b1;
    amount     = bus.i_Shamt;
    logic_res  = '0;
    case (bus.i_ALUOp)
      OP_ADD:  logic_res = bus.i_DatoA + bus.i_DatoB;
      OP_SUB:  logic_res = bus.i_DatoA - bus.i_DatoB;
      OP_AND:  logic_res = bus.i_DatoA & bus.i_DatoB;
      OP_OR:   logic_res = bus.i_DatoA | bus.i_DatoB;
      OP_NOR:  logic_res = ~(bus.i_DatoA | bus.i_DatoB);
      OP_XOR:  logic_res = bus.i_DatoA ^ bus.i_DatoB;
      OP_SLT:  logic_res = {{(NBITS-1){1'b0}}, ($signed(bus.i_DatoA) < $signed(bus.i_DatoB))};
      OP_SLL:  begin
        is_shift   = 1'b1;
        shift_left = 1'b1;
      end
      OP_SRL:  is_shift = 1'b1;
      OP_SLLV: begin
        is_shift   = 1'b1;
        shift_left = 1'b1;
        amount     = bus.i_DatoA[NBSHAMT-1:0];
      end
      OP_SRLV: begin
        is_shift = 1'b1;
        amount   = bus.i_DatoA[NBSHAMT-1:0];
      end
      default: begin
        legal     = 1'b0;
        logic_res = ILLEGAL_RESULT;
      end
    endcase
  end

  // Shifts of 0 or 1 finish in the accept cycle; longer ones go through the shift unit.
  always_comb begin
    alu_res = logic_res;
    if (is_shift) begin
`ifdef ALU_FAST_SHIFT_EN
      alu_res = sh_res;
`else
      alu_res = (amount == '0) ? bus.i_DatoB : shift_one(bus.i_DatoB, shift_left);
`endif
    end
  end

  alu_shift_unit u_shift (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .load   (accept && go_shift),
    .left   (shift_left),
    .data   (bus.i_DatoB),
    .amount (amount),
    .result (sh_res),
    .last   (sh_last)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      error_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (go_shift) begin
          state <= ST_SHIFT;
        end else begin
          state    <= ST_DONE;
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
          error_q  <= !legal;
        end
`ifndef ALU_FAST_SHIFT_EN
      end else if (state == ST_SHIFT) begin
        if (sh_last) begin
          state    <= ST_DONE;
          result_q <= sh_res;
          zero_q   <= (sh_res == '0);
          error_q  <= 1'b0;
        end
`endif
      end else if ((state == ST_DONE) && bus.i_Ready) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder, together with the two operands and the shift amount. It computes the result and registers it with a zero flag into a single-entry output register. Valid/ready handshakes sit on both sides. By default, shifts are performed iteratively at one bit per cycle, which makes the block multi-cycle for shifts and single-cycle for everything else.

## Interface
- NBITS, 32, datapath width
- ALUOP, 4, operation code width
- NBSHAMT, 5, shift amount width (log2 NBITS)

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_Valid  in  1  operation presented
- o_Ready  out  1  block accepts operation this cycle
- i_ALUOp  in  ALUOP  operation code
- i_DatoA  in  NBITS  rs operand
- i_DatoB  in  NBITS  rt or extended-immediate operand
- i_Shamt  in  NBSHAMT  instruction shamt field
- o_Valid  out  1  result register holds a result
- i_Ready  in  1  downstream takes result
- o_Result  out  NBITS  registered result
- o_Zero  out  1  registered (o_Result == 0)
- o_Error  out  1  registered: op code was illegal

## Operation
- Acceptance when i_Valid && o_Ready. Inputs are sampled only at acceptance.
- Op codes:
  - 0010: A+B (wraps, no overflow trap)
  - 0110: A−B
  - 0000: A&B
  - 0001: A|B
  - 1100: ~(A|B)
  - 1101: A^B
  - 0111: signed A<B → 1, else 0
  - 0011: B<<shamt
  - 0100: B>>shamt (logical)
  - 0101: B<<A[4:0]
  - 1000: B>>A[4:0]
- Any other code is illegal: result 0, o_Zero=1, o_Error=1. Completes like a non-shift op.
- State machine:
  - IDLE: output empty. On accept of a non-shift op, or a shift with amount 0, go to DONE. On accept of a shift with amount n>0, load B and count=n, go to SHIFT.
  - SHIFT: each cycle, shift the working register 1 bit in the selected direction and decrement count. When count reaches 1, write the final value into the output register and go to DONE.
  - DONE: o_Valid=1.
    - i_Ready && i_Valid with a non-shift op: new result loaded; stay in DONE.
    - i_Ready && i_Valid with a shift n>0: go to SHIFT.
    - i_Ready && !i_Valid: go to IDLE.
    - !i_Ready: hold o_Result, o_Zero and o_Error stable.
- o_Ready = (state==IDLE) || (state==DONE && i_Ready). o_Ready is low throughout SHIFT.
- o_Error clears on the next accepted legal op.

## Timing
- Reset values (all asynchronous): state=IDLE, o_Valid=0, o_Ready=1 (combinational from IDLE), o_Result=0, o_Zero=1, o_Error=0, count=0.
- Non-shift op, or shift by 0: o_Valid rises on the edge after acceptance (latency 1). Throughput is 1 op/cycle when i_Ready is held high.
- Shift by n>0 (iterative): o_Valid rises n edges after acceptance. Max latency is 31.
- i_Valid may drop at any time without penalty. o_Valid never drops without i_Ready.
- Reset asserted mid-shift abandons the operation immediately. No partial result is ever shown.
- Shift amount is always taken from the low 5 bits. Upper bits of A are ignored for variable shifts.

## Configuration
- ALU_FAST_SHIFT_EN defined: a barrel shifter handles all shifts in a single cycle with latency 1. The SHIFT state and counter are not built, and o_Ready = !o_Valid || i_Ready.
- ALU_FAST_SHIFT_EN undefined: iterative 1-bit/cycle shifting as described above.

## Structure
- Shared package alu_pkg holds:
  - localparams for the eleven op codes
  - the state enum (IDLE, SHIFT, DONE)
  - the illegal-op result constant
- The decoder and this block both import alu_pkg.
- One sub-module, alu_shift_unit, contains the working register, down-counter and direction. Its body is under the ALU_FAST_SHIFT_EN ifdef, with a combinational barrel or iterative implementation.

## Test plan
- After reset, check o_Valid=0, o_Result=0, o_Zero=1, o_Ready=1. Then apply op 0110 with A=5, B=5 → next cycle o_Result=0, o_Zero=1.
- Op 0111 with A=0xFFFFFFFF, B=1 → o_Result=1. Op 0111 with A=1, B=0xFFFFFFFF → o_Result=0.
- Op 0011 with B=1, shamt=31, built without the macro → o_Valid high exactly 31 cycles after accept, o_Result=0x80000000, o_Ready low throughout. With the macro → 1 cycle.
- Back-to-back ADD ops with i_Ready held low for 3 cycles → first result stable, o_Ready=0. Release i_Ready → one result per cycle, none lost or duplicated.
- Op 1111 → o_Error=1, o_Result=0. The following 0010 with A=2, B=3 → o_Error=0, o_Result=5.
- Reset asserted at the 10th cycle of a 20-bit SRLV → all outputs return to reset values in the same cycle, no o_Valid afterwards.
